// File: rtl/adder_position_inverse.sv
// Bit-serial subtractor that recovers the unknown addend (sum - addend), LSB first,
// with a registered ripple borrow and a flag for results outside the WIDTH-bit range.
module adder_position_inverse #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum_in,
  input  logic [WIDTH-1:0] addend_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             err_out
);

  localparam int CW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_r;
  logic [WIDTH:0] sum_r;
  logic [WIDTH:0] add_r;
  logic [WIDTH:0] res_r;
  logic [CW-1:0]  cnt_r;
  logic           borrow_r;

  logic [1:0]     step_s;
  logic [WIDTH:0] res_next_s;

  // One full-subtractor bit: returns {borrow_out, difference_bit}
  function automatic logic [1:0] sub_bit(input logic s, input logic a, input logic b);
    sub_bit = {(~s & a) | (~(s ^ a) & b), s ^ a ^ b};
  endfunction

  // Current serial step and the result register as it will look after this step
  always_comb begin
    step_s     = sub_bit(sum_r[0], add_r[0], borrow_r);
    res_next_s = {step_s[0], res_r[WIDTH:1]};
  end

  // Handshake FSM, serial datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      sum_r     <= '0;
      add_r     <= '0;
      res_r     <= '0;
      cnt_r     <= '0;
      borrow_r  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff_out  <= '0;
      err_out   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sum_r    <= sum_in;
            add_r    <= {1'b0, addend_in};
            res_r    <= '0;
            cnt_r    <= '0;
            borrow_r <= 1'b0;
            in_ready <= 1'b0;
            state_r  <= SHIFT;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SHIFT: begin
          sum_r    <= {1'b0, sum_r[WIDTH:1]};
          add_r    <= {1'b0, add_r[WIDTH:1]};
          res_r    <= res_next_s;
          borrow_r <= step_s[1];
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH)) begin
            // A borrow out of the MSB means the true difference was negative
            diff_out  <= res_next_s[WIDTH-1:0];
            err_out   <= step_s[1] | res_next_s[WIDTH];
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_position_inverse.sv
// Directed and exhaustive bench for adder_position_inverse at WIDTH=2.
module tb_adder_position_inverse;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sum_in;
  logic [1:0] addend_in;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] diff_out;
  logic       err_out;

  int checks;
  int errors;

  adder_position_inverse #(.WIDTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .addend_in (addend_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff_out  (diff_out),
    .err_out   (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, wait for the result, compare against the
  // reference model, then consume it. lat = edges from accept edge to out_valid.
  task automatic do_op(input logic [2:0] s, input logic [1:0] a, output int lat);
    int d;
    logic [1:0] exp_d;
    logic       exp_e;
    d     = int'(s) - int'(a);
    exp_d = d[1:0];
    exp_e = (d < 0) || (d > 3);
    chk("in_ready_idle", {7'd0, in_ready}, 8'd1);
    in_valid  = 1'b1;
    sum_in    = s;
    addend_in = a;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk($sformatf("timeout s=%0d a=%0d", s, a), {7'd0, out_valid}, 8'd1);
    chk($sformatf("diff s=%0d a=%0d", s, a), {6'd0, diff_out}, {6'd0, exp_d});
    chk($sformatf("err s=%0d a=%0d", s, a), {7'd0, err_out}, {7'd0, exp_e});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_drop", {7'd0, out_valid}, 8'd0);
  endtask

  initial begin
    int lat;
    logic [1:0] hold_d;
    logic       hold_e;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sum_in    = 3'd0;
    addend_in = 2'd0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_diff", {6'd0, diff_out}, 8'd0);
    chk("rst_err", {7'd0, err_out}, 8'd0);
    rst_n = 1'b1;
    step();

    // 5-3: check latency cycle by cycle
    in_valid  = 1'b1;
    sum_in    = 3'd5;
    addend_in = 2'd3;
    step();
    in_valid = 1'b0;
    chk("busy_in_ready", {7'd0, in_ready}, 8'd0);
    chk("lat_e1", {7'd0, out_valid}, 8'd0);
    step();
    chk("lat_e2", {7'd0, out_valid}, 8'd0);
    step();
    chk("lat_e3", {7'd0, out_valid}, 8'd0);
    step();
    chk("lat_e4", {7'd0, out_valid}, 8'd1);
    chk("diff_5_3", {6'd0, diff_out}, 8'd2);
    chk("err_5_3", {7'd0, err_out}, 8'd0);
    chk("done_in_ready", {7'd0, in_ready}, 8'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_out_valid", {7'd0, out_valid}, 8'd0);

    do_op(3'd6, 2'd3, lat);
    chk("lat_6_3", 8'(lat), 8'd3);
    do_op(3'd7, 2'd0, lat);
    do_op(3'd1, 2'd2, lat);

    // Backpressure: hold out_ready low, offer new data that must be ignored
    in_valid  = 1'b1;
    sum_in    = 3'd4;
    addend_in = 2'd1;
    step();
    sum_in    = 3'd0;
    addend_in = 2'd3;
    step();
    step();
    step();
    chk("bp_valid", {7'd0, out_valid}, 8'd1);
    hold_d = diff_out;
    hold_e = err_out;
    chk("bp_diff", {6'd0, hold_d}, 8'd3);
    chk("bp_err", {7'd0, hold_e}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold_valid%0d", i), {7'd0, out_valid}, 8'd1);
      chk($sformatf("bp_hold_diff%0d", i), {6'd0, diff_out}, 8'd3);
      chk($sformatf("bp_hold_ready%0d", i), {7'd0, in_ready}, 8'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release", {7'd0, out_valid}, 8'd0);
    chk("bp_idle_ready", {7'd0, in_ready}, 8'd1);

    // Reset in the second SHIFT cycle
    in_valid  = 1'b1;
    sum_in    = 3'd7;
    addend_in = 2'd1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("mid_rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("mid_rst_diff", {6'd0, diff_out}, 8'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_rst_quiet%0d", i), {7'd0, out_valid}, 8'd0);
    end
    do_op(3'd3, 2'd1, lat);

    // Exhaustive sweep
    for (int s = 0; s < 8; s++) begin
      for (int a = 0; a < 4; a++) begin
        do_op(3'(s), 2'(a), lat);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
